// File: rtl/odd_issue_stage_if.sv
// rtl/odd_issue_stage_if.sv - decoded-instruction handshake and issued-instruction bus of the odd issue stage
interface odd_issue_stage_if;
  // decoder side
  logic        in_valid;
  logic        in_ready;
  logic [0:10] in_op;
  logic [2:0]  in_format;
  logic [1:0]  in_unit;
  logic [0:6]  in_rt_addr;
  logic [0:6]  in_ra_addr;
  logic [0:6]  in_rb_addr;
  logic [0:6]  in_rc_addr;
  logic [2:0]  in_src_use;
  logic [0:17] in_imm;
  logic        in_reg_write;
  logic [7:0]  in_pc;
  logic        in_first;
  logic        branch_taken;

  // odd pipe side
  logic [0:10] op;
  logic [2:0]  format;
  logic [1:0]  unit;
  logic [0:6]  rt_addr;
  logic [0:6]  ra_addr;
  logic [0:6]  rb_addr;
  logic [0:6]  rc_addr;
  logic [0:17] imm;
  logic        reg_write;
  logic [7:0]  pc_out;
  logic        first;
  logic        issue_valid;
  logic [15:0] stall_cycles;

  modport master (
    output in_valid, in_op, in_format, in_unit, in_rt_addr, in_ra_addr,
           in_rb_addr, in_rc_addr, in_src_use, in_imm, in_reg_write, in_pc,
           in_first, branch_taken,
    input  in_ready, op, format, unit, rt_addr, ra_addr, rb_addr, rc_addr,
           imm, reg_write, pc_out, first, issue_valid, stall_cycles
  );

  modport slave (
    input  in_valid, in_op, in_format, in_unit, in_rt_addr, in_ra_addr,
           in_rb_addr, in_rc_addr, in_src_use, in_imm, in_reg_write, in_pc,
           in_first, branch_taken,
    output in_ready, op, format, unit, rt_addr, ra_addr, rb_addr, rc_addr,
           imm, reg_write, pc_out, first, issue_valid, stall_cycles
  );
endinterface

// File: rtl/odd_issue_stage.sv
// rtl/odd_issue_stage.sv - odd-pipe issue stage: single-entry hold register, latency scoreboard, registered issue
module odd_issue_stage #(
  parameter logic [2:0] LAT_PERM = 3'd4,
  parameter logic [2:0] LAT_LS   = 3'd6,
  parameter logic [2:0] LAT_BR   = 3'd1,
  parameter int         SB_DEPTH = 8
) (
  input logic              clk,
  input logic              reset,
  odd_issue_stage_if.slave bus
);

  // hold register
  logic        h_valid_q, h_valid_d;
  logic [0:10] h_op_q, h_op_d;
  logic [2:0]  h_format_q, h_format_d;
  logic [1:0]  h_unit_q, h_unit_d;
  logic [0:6]  h_rt_q, h_rt_d;
  logic [0:6]  h_ra_q, h_ra_d;
  logic [0:6]  h_rb_q, h_rb_d;
  logic [0:6]  h_rc_q, h_rc_d;
  logic [2:0]  h_src_use_q, h_src_use_d;
  logic [0:17] h_imm_q, h_imm_d;
  logic        h_reg_write_q, h_reg_write_d;
  logic [7:0]  h_pc_q, h_pc_d;
  logic        h_first_q, h_first_d;

  // issued instruction register
  logic        o_valid_q, o_valid_d;
  logic [0:10] o_op_q, o_op_d;
  logic [2:0]  o_format_q, o_format_d;
  logic [1:0]  o_unit_q, o_unit_d;
  logic [0:6]  o_rt_q, o_rt_d;
  logic [0:6]  o_ra_q, o_ra_d;
  logic [0:6]  o_rb_q, o_rb_d;
  logic [0:6]  o_rc_q, o_rc_d;
  logic [0:17] o_imm_q, o_imm_d;
  logic        o_reg_write_q, o_reg_write_d;
  logic [7:0]  o_pc_q, o_pc_d;
  logic        o_first_q, o_first_d;

  // scoreboard
  logic [0:6]          sb_addr_q [SB_DEPTH];
  logic [0:6]          sb_addr_d [SB_DEPTH];
  logic [2:0]          sb_rem_q  [SB_DEPTH];
  logic [2:0]          sb_rem_d  [SB_DEPTH];
  logic [SB_DEPTH-1:0] free_sel;

  logic [15:0] stall_q, stall_d;

  logic       hazard;
  logic       issue_now;
  logic       accept;
  logic       in_ready;
  logic       sb_load;
  logic [2:0] lat_sel;

  // A live slot blocks H only through a source the instruction actually reads.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_rem_q[i] != 3'd0) begin
        if (h_src_use_q[2] && sb_addr_q[i] == h_ra_q) hazard = 1'b1;
        if (h_src_use_q[1] && sb_addr_q[i] == h_rb_q) hazard = 1'b1;
        if (h_src_use_q[0] && sb_addr_q[i] == h_rc_q) hazard = 1'b1;
      end
    end
    hazard = hazard & h_valid_q;
  end

  assign issue_now = h_valid_q && !hazard && !bus.branch_taken;
  assign in_ready  = !bus.branch_taken && (!h_valid_q || issue_now);
  assign accept    = bus.in_valid && in_ready;
  assign sb_load   = issue_now && h_reg_write_q;

  always_comb begin
    case (h_unit_q)
      2'd1:    lat_sel = LAT_LS;
      2'd2:    lat_sel = LAT_BR;
      default: lat_sel = LAT_PERM;
    endcase
  end

  // lowest-index free slot, one-hot
  always_comb begin
    logic taken;
    taken    = 1'b0;
    free_sel = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (!taken && sb_rem_q[i] == 3'd0) begin
        free_sel[i] = 1'b1;
        taken       = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      sb_addr_d[i] = sb_addr_q[i];
      sb_rem_d[i]  = (sb_rem_q[i] != 3'd0) ? sb_rem_q[i] - 3'd1 : 3'd0;
      if (sb_load && free_sel[i]) begin
        sb_addr_d[i] = h_rt_q;
        sb_rem_d[i]  = lat_sel;
      end
    end
  end

  // Flush wins over everything; in_ready already blocks accept during a flush.
  always_comb begin
    h_valid_d     = h_valid_q;
    h_op_d        = h_op_q;
    h_format_d    = h_format_q;
    h_unit_d      = h_unit_q;
    h_rt_d        = h_rt_q;
    h_ra_d        = h_ra_q;
    h_rb_d        = h_rb_q;
    h_rc_d        = h_rc_q;
    h_src_use_d   = h_src_use_q;
    h_imm_d       = h_imm_q;
    h_reg_write_d = h_reg_write_q;
    h_pc_d        = h_pc_q;
    h_first_d     = h_first_q;
    if (bus.branch_taken) begin
      h_valid_d = 1'b0;
    end else if (accept) begin
      h_valid_d     = 1'b1;
      h_op_d        = bus.in_op;
      h_format_d    = bus.in_format;
      h_unit_d      = bus.in_unit;
      h_rt_d        = bus.in_rt_addr;
      h_ra_d        = bus.in_ra_addr;
      h_rb_d        = bus.in_rb_addr;
      h_rc_d        = bus.in_rc_addr;
      h_src_use_d   = bus.in_src_use;
      h_imm_d       = bus.in_imm;
      h_reg_write_d = bus.in_reg_write;
      h_pc_d        = bus.in_pc;
      h_first_d     = bus.in_first;
    end else if (issue_now) begin
      h_valid_d = 1'b0;
    end
  end

  always_comb begin
    o_valid_d     = 1'b0;
    o_op_d        = '0;
    o_format_d    = '0;
    o_unit_d      = '0;
    o_rt_d        = '0;
    o_ra_d        = '0;
    o_rb_d        = '0;
    o_rc_d        = '0;
    o_imm_d       = '0;
    o_reg_write_d = 1'b0;
    o_pc_d        = '0;
    o_first_d     = 1'b0;
    if (issue_now) begin
      o_valid_d     = 1'b1;
      o_op_d        = h_op_q;
      o_format_d    = h_format_q;
      o_unit_d      = h_unit_q;
      o_rt_d        = h_rt_q;
      o_ra_d        = h_ra_q;
      o_rb_d        = h_rb_q;
      o_rc_d        = h_rc_q;
      o_imm_d       = h_imm_q;
      o_reg_write_d = h_reg_write_q;
      o_pc_d        = h_pc_q;
      o_first_d     = h_first_q;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard && !bus.branch_taken && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_valid_q     <= 1'b0;
      h_op_q        <= '0;
      h_format_q    <= '0;
      h_unit_q      <= '0;
      h_rt_q        <= '0;
      h_ra_q        <= '0;
      h_rb_q        <= '0;
      h_rc_q        <= '0;
      h_src_use_q   <= '0;
      h_imm_q       <= '0;
      h_reg_write_q <= 1'b0;
      h_pc_q        <= '0;
      h_first_q     <= 1'b0;
      o_valid_q     <= 1'b0;
      o_op_q        <= '0;
      o_format_q    <= '0;
      o_unit_q      <= '0;
      o_rt_q        <= '0;
      o_ra_q        <= '0;
      o_rb_q        <= '0;
      o_rc_q        <= '0;
      o_imm_q       <= '0;
      o_reg_write_q <= 1'b0;
      o_pc_q        <= '0;
      o_first_q     <= 1'b0;
      stall_q       <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_rem_q[i]  <= '0;
      end
    end else begin
      h_valid_q     <= h_valid_d;
      h_op_q        <= h_op_d;
      h_format_q    <= h_format_d;
      h_unit_q      <= h_unit_d;
      h_rt_q        <= h_rt_d;
      h_ra_q        <= h_ra_d;
      h_rb_q        <= h_rb_d;
      h_rc_q        <= h_rc_d;
      h_src_use_q   <= h_src_use_d;
      h_imm_q       <= h_imm_d;
      h_reg_write_q <= h_reg_write_d;
      h_pc_q        <= h_pc_d;
      h_first_q     <= h_first_d;
      o_valid_q     <= o_valid_d;
      o_op_q        <= o_op_d;
      o_format_q    <= o_format_d;
      o_unit_q      <= o_unit_d;
      o_rt_q        <= o_rt_d;
      o_ra_q        <= o_ra_d;
      o_rb_q        <= o_rb_d;
      o_rc_q        <= o_rc_d;
      o_imm_q       <= o_imm_d;
      o_reg_write_q <= o_reg_write_d;
      o_pc_q        <= o_pc_d;
      o_first_q     <= o_first_d;
      stall_q       <= stall_d;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= sb_addr_d[i];
        sb_rem_q[i]  <= sb_rem_d[i];
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.issue_valid  = o_valid_q;
  assign bus.op           = o_op_q;
  assign bus.format       = o_format_q;
  assign bus.unit         = o_unit_q;
  assign bus.rt_addr      = o_rt_q;
  assign bus.ra_addr      = o_ra_q;
  assign bus.rb_addr      = o_rb_q;
  assign bus.rc_addr      = o_rc_q;
  assign bus.imm          = o_imm_q;
  assign bus.reg_write    = o_reg_write_q;
  assign bus.pc_out       = o_pc_q;
  assign bus.first        = o_first_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_odd_issue_stage.sv
// tb/tb_odd_issue_stage.sv - directed-vector bench for odd_issue_stage
module tb_odd_issue_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  odd_issue_stage_if bus ();

  odd_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] op_of(input logic [6:0] rt);
    return {4'b1010, rt};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic v, input logic [1:0] u, input logic [6:0] rt,
                        input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                        input logic [2:0] use_bits, input logic rw);
    bus.in_valid     = v;
    bus.in_unit      = u;
    bus.in_rt_addr   = rt;
    bus.in_ra_addr   = ra;
    bus.in_rb_addr   = rb;
    bus.in_rc_addr   = rc;
    bus.in_src_use   = use_bits;
    bus.in_reg_write = rw;
    bus.in_op        = op_of(rt);
    bus.in_format    = rt[2:0];
    bus.in_imm       = {11'd0, rt};
    bus.in_pc        = 8'd100 + {1'b0, rt};
    bus.in_first     = rt[0];
  endtask

  task automatic set_idle();
    set_in(1'b0, 2'd0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0);
  endtask

  // producer then dependent; measure edges from producer issue to dependent issue
  task automatic raw_pair(input string tag, input logic [1:0] pu, input logic [6:0] prt,
                          input logic [1:0] du, input logic [6:0] dra, input logic [6:0] drb,
                          input logic [6:0] drc, input logic [2:0] duse,
                          input int exp_gap, input int exp_stall);
    logic [15:0] s0;
    int n;
    s0 = bus.stall_cycles;
    set_in(1'b1, pu, prt, 7'd1, 7'd2, 7'd5, 3'b000, 1'b1);
    step();
    set_in(1'b1, du, 7'd99, dra, drb, drc, duse, 1'b0);
    step();
    chk({tag, "_prod"}, 32'(bus.issue_valid && bus.rt_addr == prt), 32'd1);
    set_idle();
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.issue_valid && n < 20);
    chk({tag, "_gap"}, 32'(n), 32'(exp_gap));
    chk({tag, "_dep_rt"}, 32'(bus.rt_addr), 32'd99);
    chk({tag, "_stall"}, 32'(bus.stall_cycles - s0), 32'(exp_stall));
    repeat (8) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] s0;
    bus.branch_taken = 1'b0;
    set_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_rw", 32'(bus.reg_write), 32'd0);
    chk("rst_op", 32'(bus.op), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    // independent stream
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 2'd0, 7'(10 + k), 7'(1 + k), 7'd0, 7'd0, 3'b100, 1'b1);
      #1;
      chk("ind_ready", 32'(bus.in_ready), 32'd1);
      step();
      if (k == 0) begin
        chk("ind_lat", 32'(bus.issue_valid), 32'd0);
      end else begin
        chk("ind_valid", 32'(bus.issue_valid), 32'd1);
        chk("ind_rt", 32'(bus.rt_addr), 32'(10 + k - 1));
      end
    end
    set_idle();
    step();
    chk("ind_last_valid", 32'(bus.issue_valid), 32'd1);
    chk("ind_last_op", 32'(bus.op), 32'(op_of(7'd14)));
    chk("ind_last_pc", 32'(bus.pc_out), 32'd114);
    chk("ind_last_imm", 32'(bus.imm), 32'd14);
    step();
    chk("ind_bubble_valid", 32'(bus.issue_valid), 32'd0);
    chk("ind_bubble_rw", 32'(bus.reg_write), 32'd0);
    chk("ind_stall", 32'(bus.stall_cycles), 32'd0);
    repeat (6) step();

    // Perm RAW with in_ready tracking
    s0 = bus.stall_cycles;
    set_in(1'b1, 2'd0, 7'd20, 7'd1, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_in(1'b1, 2'd0, 7'd21, 7'd20, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_idle();
    #1;
    chk("perm_prod_rt", 32'(bus.rt_addr), 32'd20);
    chk("perm_prod_rw", 32'(bus.reg_write), 32'd1);
    chk("perm_ready0", 32'(bus.in_ready), 32'd0);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("perm_ready_lo", 32'(bus.in_ready), 32'd0);
      chk("perm_stalled", 32'(bus.issue_valid), 32'd0);
    end
    step();
    chk("perm_ready_hi", 32'(bus.in_ready), 32'd1);
    chk("perm_not_yet", 32'(bus.issue_valid), 32'd0);
    step();
    chk("perm_dep_valid", 32'(bus.issue_valid), 32'd1);
    chk("perm_dep_rt", 32'(bus.rt_addr), 32'd21);
    chk("perm_stall", 32'(bus.stall_cycles - s0), 32'd4);
    repeat (6) step();

    raw_pair("ls_rc",   2'd1, 7'd7,  2'd1, 7'd0,  7'd0, 7'd7, 3'b001, 7, 6);
    raw_pair("br_rb",   2'd2, 7'd3,  2'd2, 7'd0,  7'd3, 7'd0, 3'b010, 2, 1);
    raw_pair("unused",  2'd0, 7'd20, 2'd0, 7'd20, 7'd0, 7'd0, 3'b000, 1, 0);
    raw_pair("unit3",   2'd3, 7'd40, 2'd0, 7'd40, 7'd0, 7'd0, 3'b100, 5, 4);
    raw_pair("reg0",    2'd0, 7'd0,  2'd0, 7'd9,  7'd9, 7'd0, 3'b001, 5, 4);

    // flush while the dependent is stalled
    s0 = bus.stall_cycles;
    set_in(1'b1, 2'd0, 7'd20, 7'd1, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_in(1'b1, 2'd0, 7'd22, 7'd20, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_idle();
    step();
    bus.branch_taken = 1'b1;
    #1;
    chk("fl_ready_lo", 32'(bus.in_ready), 32'd0);
    step();
    bus.branch_taken = 1'b0;
    #1;
    chk("fl_no_issue", 32'(bus.issue_valid), 32'd0);
    chk("fl_ready_hi", 32'(bus.in_ready), 32'd1);
    set_in(1'b1, 2'd0, 7'd23, 7'd20, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_idle();
    chk("fl_sb_hold1", 32'(bus.issue_valid), 32'd0);
    step();
    chk("fl_sb_hold2", 32'(bus.issue_valid), 32'd0);
    step();
    chk("fl_new_valid", 32'(bus.issue_valid), 32'd1);
    chk("fl_new_rt", 32'(bus.rt_addr), 32'd23);
    chk("fl_stall", 32'(bus.stall_cycles - s0), 32'd2);
    repeat (6) step();

    // reset with a stalled H and three live slots
    set_in(1'b1, 2'd0, 7'd30, 7'd1, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_in(1'b1, 2'd0, 7'd31, 7'd1, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_in(1'b1, 2'd0, 7'd32, 7'd1, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_in(1'b1, 2'd0, 7'd34, 7'd32, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_idle();
    step();
    chk("rs_stalled", 32'(bus.issue_valid), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rs_valid", 32'(bus.issue_valid), 32'd0);
    chk("rs_ready", 32'(bus.in_ready), 32'd1);
    chk("rs_stall", 32'(bus.stall_cycles), 32'd0);
    set_in(1'b1, 2'd0, 7'd33, 7'd32, 7'd0, 7'd0, 3'b100, 1'b1);
    step();
    set_idle();
    chk("rs_accept_bubble", 32'(bus.issue_valid), 32'd0);
    step();
    chk("rs_dep_valid", 32'(bus.issue_valid), 32'd1);
    chk("rs_dep_rt", 32'(bus.rt_addr), 32'd33);
    chk("rs_dep_stall", 32'(bus.stall_cycles), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
